rs_param: RTL and testbench

- Parametrised reservation station for the out-of-order core; next generation of the fixed 8-entry, 3-port issue queue.
- Receives up to DISP_N renamed uops per cycle from dispatch, tracks source-operand readiness through WB_N result broadcasts, and issues one ready uop per cycle to its functional unit.
- Selection is oldest-first (age matrix), not lowest-index.
- Uses a valid/ready issue handshake and an all-or-nothing dispatch stall, replacing the fixed freeze inputs.

---
 rtl/rs_param.sv | 229 ++++++++++++++++++++++
 tb/tb_rs_param.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_param.sv
// rs_param: parametrised reservation station.
//   Accepts up to DISP_N renamed uops per cycle (all-or-nothing), tracks
//   source readiness from WB_N result broadcasts, and issues the oldest
//   ready uop through a valid/ready issue register.
// Ports:
//   clk, rst (async, active-low), flush (sync kill of entries + issue reg)
//   disp_valid/pa/pb/pw/rdy_a/rdy_b/rob : per-port dispatch slices
//   disp_stall : dispatch rejected this cycle (combinational)
//   free_cnt   : number of free entries, from registered state
//   wb_valid/wb_pw : result broadcast buses
//   iss_valid/iss_ready/iss_pa/iss_pb/iss_pw/iss_rob : issue handshake
module rs_param #(
    parameter int DEPTH  = 8,
    parameter int DISP_N = 3,
    parameter int WB_N   = 2,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [DISP_N-1:0]            disp_valid,
    input  logic [DISP_N*PREG_W-1:0]     disp_pa,
    input  logic [DISP_N*PREG_W-1:0]     disp_pb,
    input  logic [DISP_N*PREG_W-1:0]     disp_pw,
    input  logic [DISP_N-1:0]            disp_rdy_a,
    input  logic [DISP_N-1:0]            disp_rdy_b,
    input  logic [DISP_N*ROB_W-1:0]      disp_rob,
    output logic                         disp_stall,
    output logic [$clog2(DEPTH+1)-1:0]   free_cnt,
    input  logic [WB_N-1:0]              wb_valid,
    input  logic [WB_N*PREG_W-1:0]       wb_pw,
    output logic                         iss_valid,
    input  logic                         iss_ready,
    output logic [PREG_W-1:0]            iss_pa,
    output logic [PREG_W-1:0]            iss_pb,
    output logic [PREG_W-1:0]            iss_pw,
    output logic [ROB_W-1:0]             iss_rob
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PORT_W = (DISP_N > 1) ? $clog2(DISP_N) : 1;

    // entry storage
    logic [DEPTH-1:0]  e_valid, e_ra, e_rb;
    logic [PREG_W-1:0] e_pa  [DEPTH];
    logic [PREG_W-1:0] e_pb  [DEPTH];
    logic [PREG_W-1:0] e_pw  [DEPTH];
    logic [ROB_W-1:0]  e_rob [DEPTH];
    // older[i][j] = 1 : entry i is older than entry j
    logic [DEPTH-1:0]  older   [DEPTH];
    logic [DEPTH-1:0]  older_n [DEPTH];

    logic [CNT_W-1:0]  n_req;
    logic [DISP_N-1:0] byp_a, byp_b;
    logic [DEPTH-1:0]  wake_a, wake_b;

    // per-entry write controls from slot allocation
    logic [DEPTH-1:0]  wr_hit;
    logic [PORT_W-1:0] wr_port [DEPTH];
    logic [PREG_W-1:0] w_pa  [DEPTH];
    logic [PREG_W-1:0] w_pb  [DEPTH];
    logic [PREG_W-1:0] w_pw  [DEPTH];
    logic [ROB_W-1:0]  w_rob [DEPTH];
    logic [DEPTH-1:0]  w_ra, w_rb;
    logic              placed;

    logic [DEPTH-1:0]  cand, win;
    logic              blocked;
    logic              load;
    logic [PREG_W-1:0] sel_pa, sel_pb, sel_pw;
    logic [ROB_W-1:0]  sel_rob;

    // occupancy and stall
    always_comb begin
        free_cnt = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            free_cnt = free_cnt + CNT_W'(~e_valid[i]);
        n_req = '0;
        for (int unsigned p = 0; p < DISP_N; p++)
            n_req = n_req + CNT_W'(disp_valid[p]);
        disp_stall = (n_req > free_cnt);
    end

    // broadcast tag match: dispatch bypass and resident-entry wakeup
    always_comb begin
        byp_a  = disp_rdy_a;
        byp_b  = disp_rdy_b;
        wake_a = '0;
        wake_b = '0;
        for (int unsigned j = 0; j < WB_N; j++) begin
            if (wb_valid[j]) begin
                for (int unsigned p = 0; p < DISP_N; p++) begin
                    if (wb_pw[j*PREG_W +: PREG_W] == disp_pa[p*PREG_W +: PREG_W]) byp_a[p] = 1'b1;
                    if (wb_pw[j*PREG_W +: PREG_W] == disp_pb[p*PREG_W +: PREG_W]) byp_b[p] = 1'b1;
                end
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (wb_pw[j*PREG_W +: PREG_W] == e_pa[i]) wake_a[i] = 1'b1;
                    if (wb_pw[j*PREG_W +: PREG_W] == e_pb[i]) wake_b[i] = 1'b1;
                end
            end
        end
    end

    // k-th valid port takes the k-th lowest free slot; nothing on stall
    always_comb begin
        wr_hit = '0;
        w_ra   = '0;
        w_rb   = '0;
        placed = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            wr_port[i] = '0;
            w_pa[i]    = '0;
            w_pb[i]    = '0;
            w_pw[i]    = '0;
            w_rob[i]   = '0;
        end
        for (int unsigned p = 0; p < DISP_N; p++) begin
            placed = 1'b0;
            if (disp_valid[p] && !disp_stall) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (!placed && !e_valid[i] && !wr_hit[i]) begin
                        placed     = 1'b1;
                        wr_hit[i]  = 1'b1;
                        wr_port[i] = PORT_W'(p);
                        w_pa[i]    = disp_pa[p*PREG_W +: PREG_W];
                        w_pb[i]    = disp_pb[p*PREG_W +: PREG_W];
                        w_pw[i]    = disp_pw[p*PREG_W +: PREG_W];
                        w_rob[i]   = disp_rob[p*ROB_W +: ROB_W];
                        w_ra[i]    = byp_a[p];
                        w_rb[i]    = byp_b[p];
                    end
                end
            end
        end
    end

    // Age update: a written column marks every resident entry and every
    // lower-port same-cycle write as older; that takes precedence over the
    // row clear of a second new entry so same-cycle writes order by port.
    always_comb begin
        for (int unsigned r = 0; r < DEPTH; r++) begin
            for (int unsigned c = 0; c < DEPTH; c++) begin
                if (wr_hit[c])
                    older_n[r][c] = e_valid[r] | (wr_hit[r] & (wr_port[r] < wr_port[c]));
                else if (wr_hit[r])
                    older_n[r][c] = 1'b0;
                else
                    older_n[r][c] = older[r][c];
            end
        end
    end

    // oldest ready entry: a candidate with no older candidate
    always_comb begin
        cand    = e_valid & e_ra & e_rb;
        win     = '0;
        blocked = 1'b0;
        sel_pa  = '0;
        sel_pb  = '0;
        sel_pw  = '0;
        sel_rob = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            blocked = 1'b0;
            for (int unsigned j = 0; j < DEPTH; j++)
                if (cand[j] && older[j][i]) blocked = 1'b1;
            win[i] = cand[i] & ~blocked;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            sel_pa  = sel_pa  | ({PREG_W{win[i]}} & e_pa[i]);
            sel_pb  = sel_pb  | ({PREG_W{win[i]}} & e_pb[i]);
            sel_pw  = sel_pw  | ({PREG_W{win[i]}} & e_pw[i]);
            sel_rob = sel_rob | ({ROB_W{win[i]}}  & e_rob[i]);
        end
        load = (~iss_valid | iss_ready) & (|cand);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_valid   <= '0;
            e_ra      <= '0;
            e_rb      <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                e_pa[i]  <= '0;
                e_pb[i]  <= '0;
                e_pw[i]  <= '0;
                e_rob[i] <= '0;
                older[i] <= '0;
            end
            iss_valid <= 1'b0;
            iss_pa    <= '0;
            iss_pb    <= '0;
            iss_pw    <= '0;
            iss_rob   <= '0;
        end else if (flush) begin
            e_valid   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                older[i] <= '0;
            iss_valid <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                older[i] <= older_n[i];
                if (wr_hit[i]) begin
                    e_valid[i] <= 1'b1;
                    e_ra[i]    <= w_ra[i];
                    e_rb[i]    <= w_rb[i];
                    e_pa[i]    <= w_pa[i];
                    e_pb[i]    <= w_pb[i];
                    e_pw[i]    <= w_pw[i];
                    e_rob[i]   <= w_rob[i];
                end else begin
                    e_ra[i] <= e_ra[i] | wake_a[i];
                    e_rb[i] <= e_rb[i] | wake_b[i];
                    if (load && win[i]) e_valid[i] <= 1'b0;
                end
            end
            if (load) begin
                iss_valid <= 1'b1;
                iss_pa    <= sel_pa;
                iss_pb    <= sel_pb;
                iss_pw    <= sel_pw;
                iss_rob   <= sel_rob;
            end else if (iss_ready) begin
                iss_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rs_param.sv
// tb_rs_param: table-driven directed vectors, hand-written corner sequences
// and randomized traffic against an age-ordered queue model of rs_param.
module tb_rs_param;

    localparam int DEPTH  = 8;
    localparam int DISP_N = 3;
    localparam int WB_N   = 2;
    localparam int PREG_W = 6;
    localparam int ROB_W  = 5;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic [DISP_N-1:0]        disp_valid;
    logic [DISP_N*PREG_W-1:0] disp_pa, disp_pb, disp_pw;
    logic [DISP_N-1:0]        disp_rdy_a, disp_rdy_b;
    logic [DISP_N*ROB_W-1:0]  disp_rob;
    logic                     disp_stall;
    logic [3:0]               free_cnt;
    logic [WB_N-1:0]          wb_valid;
    logic [WB_N*PREG_W-1:0]   wb_pw;
    logic                     iss_valid, iss_ready;
    logic [PREG_W-1:0]        iss_pa, iss_pb, iss_pw;
    logic [ROB_W-1:0]         iss_rob;

    rs_param #(.DEPTH(DEPTH), .DISP_N(DISP_N), .WB_N(WB_N), .PREG_W(PREG_W), .ROB_W(ROB_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_pa(disp_pa), .disp_pb(disp_pb), .disp_pw(disp_pw),
        .disp_rdy_a(disp_rdy_a), .disp_rdy_b(disp_rdy_b), .disp_rob(disp_rob),
        .disp_stall(disp_stall), .free_cnt(free_cnt),
        .wb_valid(wb_valid), .wb_pw(wb_pw),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_pa(iss_pa), .iss_pb(iss_pb), .iss_pw(iss_pw), .iss_rob(iss_rob)
    );

    always #5 clk = ~clk;

    // reference model: resident uops kept oldest-first
    typedef struct {
        logic [PREG_W-1:0] pa, pb, pw;
        logic [ROB_W-1:0]  rob;
        bit                ra, rb;
    } ent_t;

    ent_t mq[$];
    bit   m_iv;
    ent_t m_iss;

    int   checks = 0;
    int   errors = 0;
    bit   use_model = 1'b0;
    logic s_stall;
    int unsigned log_q[$];

    typedef struct {
        logic [2:0]        dv;
        logic [PREG_W-1:0] pa, pb;
        logic [ROB_W-1:0]  rob0;
        logic [1:0]        wbv;
        logic [PREG_W-1:0] wb0, wb1;
        bit                fl;
        bit                e_stall;
        int                e_free;
        bit                e_iv;
        logic [ROB_W-1:0]  e_rob;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit wb_hit(input logic [PREG_W-1:0] t);
        for (int j = 0; j < WB_N; j++)
            if (wb_valid[j] && wb_pw[j*PREG_W +: PREG_W] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_stall();
        return $countones(disp_valid) > (DEPTH - mq.size());
    endfunction

    task automatic model_reset();
        mq.delete();
        m_iv  = 1'b0;
        m_iss = '{default: '0};
    endtask

    // one clock edge of the model, using the inputs present at that edge
    task automatic model_edge();
        bit   st, ld;
        int   idx;
        ent_t e;
        if (flush) begin
            mq.delete();
            m_iv = 1'b0;
            return;
        end
        st  = m_stall();
        idx = -1;
        for (int i = 0; i < mq.size(); i++)
            if (idx < 0 && mq[i].ra && mq[i].rb) idx = i;
        ld = (!m_iv || iss_ready) && (idx >= 0);
        for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
            if (wb_hit(e.pa)) e.ra = 1'b1;
            if (wb_hit(e.pb)) e.rb = 1'b1;
            mq[i] = e;
        end
        if (ld) begin
            m_iss = mq[idx];
            m_iv  = 1'b1;
            mq.delete(idx);
        end else if (iss_ready) begin
            m_iv = 1'b0;
        end
        if (!st) begin
            for (int p = 0; p < DISP_N; p++) begin
                if (disp_valid[p]) begin
                    e.pa  = disp_pa[p*PREG_W +: PREG_W];
                    e.pb  = disp_pb[p*PREG_W +: PREG_W];
                    e.pw  = disp_pw[p*PREG_W +: PREG_W];
                    e.rob = disp_rob[p*ROB_W +: ROB_W];
                    e.ra  = disp_rdy_a[p] | wb_hit(e.pa);
                    e.rb  = disp_rdy_b[p] | wb_hit(e.pb);
                    mq.push_back(e);
                end
            end
        end
    endtask

    task automatic idle();
        flush      = 1'b0;
        disp_valid = '0;
        disp_pa    = '0;
        disp_pb    = '0;
        disp_pw    = '0;
        disp_rdy_a = '0;
        disp_rdy_b = '0;
        disp_rob   = '0;
        wb_valid   = '0;
        wb_pw      = '0;
    endtask

    task automatic set_port(input int p, input logic [PREG_W-1:0] pa, input logic [PREG_W-1:0] pb,
                            input logic [PREG_W-1:0] pw, input bit ra, input bit rb,
                            input logic [ROB_W-1:0] rob);
        disp_valid[p]                = 1'b1;
        disp_pa[p*PREG_W +: PREG_W]  = pa;
        disp_pb[p*PREG_W +: PREG_W]  = pb;
        disp_pw[p*PREG_W +: PREG_W]  = pw;
        disp_rdy_a[p]                = ra;
        disp_rdy_b[p]                = rb;
        disp_rob[p*ROB_W +: ROB_W]   = rob;
    endtask

    task automatic set_wb(input int j, input logic [PREG_W-1:0] t);
        wb_valid[j]                = 1'b1;
        wb_pw[j*PREG_W +: PREG_W]  = t;
    endtask

    // inputs are applied beforehand; returns 1 time unit after the edge
    task automatic step();
        @(negedge clk);
        s_stall = disp_stall;
        if (iss_valid && iss_ready) log_q.push_back(32'(iss_rob));
        if (use_model) chk("disp_stall", 32'(disp_stall), 32'(m_stall()));
        @(posedge clk);
        model_edge();
        #1;
        if (use_model) begin
            chk("iss_valid", 32'(iss_valid), 32'(m_iv));
            chk("free_cnt", 32'(free_cnt), 32'(DEPTH - mq.size()));
            if (m_iv) begin
                chk("iss_rob", 32'(iss_rob), 32'(m_iss.rob));
                chk("iss_pa", 32'(iss_pa), 32'(m_iss.pa));
                chk("iss_pb", 32'(iss_pb), 32'(m_iss.pb));
                chk("iss_pw", 32'(iss_pw), 32'(m_iss.pw));
            end
        end
    endtask

    task automatic chk_log(input string nm, input int unsigned exp[$]);
        chk({nm, "_len"}, 32'(log_q.size()), 32'(exp.size()));
        for (int k = 0; k < exp.size() && k < log_q.size(); k++)
            chk($sformatf("%s_%0d", nm, k), log_q[k], exp[k]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        // dv  pa  pb  rob0 wbv  wb0 wb1  fl stall free iv rob
        tbl[0]  = '{3'b111, 6'd5,  6'd6,  5'd1,  2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 5, 1'b0, 5'd0};
        tbl[1]  = '{3'b000, 6'd0,  6'd0,  5'd0,  2'b11, 6'd5, 6'd6, 1'b0, 1'b0, 5, 1'b0, 5'd0};
        tbl[2]  = '{3'b000, 6'd0,  6'd0,  5'd0,  2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 6, 1'b1, 5'd1};
        tbl[3]  = '{3'b000, 6'd0,  6'd0,  5'd0,  2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 7, 1'b1, 5'd2};
        tbl[4]  = '{3'b000, 6'd0,  6'd0,  5'd0,  2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 8, 1'b1, 5'd3};
        tbl[5]  = '{3'b000, 6'd0,  6'd0,  5'd0,  2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 8, 1'b0, 5'd0};
        tbl[6]  = '{3'b111, 6'd20, 6'd21, 5'd4,  2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 5, 1'b0, 5'd0};
        tbl[7]  = '{3'b111, 6'd20, 6'd21, 5'd8,  2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 2, 1'b0, 5'd0};
        tbl[8]  = '{3'b111, 6'd20, 6'd21, 5'd12, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1, 2, 1'b0, 5'd0};
        tbl[9]  = '{3'b011, 6'd20, 6'd21, 5'd12, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 0, 1'b0, 5'd0};
        tbl[10] = '{3'b001, 6'd20, 6'd21, 5'd14, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1, 0, 1'b0, 5'd0};
        tbl[11] = '{3'b000, 6'd0,  6'd0,  5'd0,  2'b00, 6'd0, 6'd0, 1'b1, 1'b0, 8, 1'b0, 5'd0};

        // reset state
        rst = 1'b0;
        iss_ready = 1'b1;
        idle();
        model_reset();
        #12;
        chk("rst_iss_valid", 32'(iss_valid), 0);
        chk("rst_free_cnt", 32'(free_cnt), DEPTH);
        chk("rst_disp_stall", 32'(disp_stall), 0);
        chk("rst_iss_rob", 32'(iss_rob), 0);
        chk("rst_iss_pa", 32'(iss_pa), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // directed table: basic wakeup/issue, fill, stall, flush
        for (int i = 0; i < 12; i++) begin
            idle();
            for (int p = 0; p < DISP_N; p++)
                if (tbl[i].dv[p])
                    set_port(p, tbl[i].pa, tbl[i].pb, PREG_W'(tbl[i].rob0 + ROB_W'(p)), 1'b0, 1'b0,
                             ROB_W'(tbl[i].rob0 + ROB_W'(p)));
            if (tbl[i].wbv[0]) set_wb(0, tbl[i].wb0);
            if (tbl[i].wbv[1]) set_wb(1, tbl[i].wb1);
            flush = tbl[i].fl;
            step();
            chk($sformatf("tbl%0d_stall", i), 32'(s_stall), 32'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_free", i), 32'(free_cnt), tbl[i].e_free);
            chk($sformatf("tbl%0d_iv", i), 32'(iss_valid), 32'(tbl[i].e_iv));
            if (tbl[i].e_iv) chk($sformatf("tbl%0d_rob", i), 32'(iss_rob), 32'(tbl[i].e_rob));
        end
        use_model = 1'b1;

        // oldest-first: rob 7 lands in a higher slot than younger rob 9
        idle(); iss_ready = 1'b1; log_q.delete();
        set_port(0, 6'd1, 6'd2, 6'd3, 1'b1, 1'b1, 5'd1);
        set_port(1, 6'd1, 6'd2, 6'd4, 1'b1, 1'b1, 5'd2);
        set_port(2, 6'd1, 6'd2, 6'd5, 1'b1, 1'b1, 5'd3);
        step();
        idle(); set_port(0, 6'd30, 6'd31, 6'd7, 1'b0, 1'b0, 5'd7); step();
        idle(); set_port(0, 6'd30, 6'd31, 6'd9, 1'b0, 1'b0, 5'd9); step();
        idle(); set_wb(0, 6'd30); set_wb(1, 6'd31); step();
        idle();
        for (int k = 0; k < 5; k++) step();
        chk_log("oldest", '{1, 2, 3, 7, 9});

        // dispatch-cycle bypass
        idle(); log_q.delete();
        set_port(0, 6'd12, 6'd13, 6'd14, 1'b0, 1'b1, 5'd12);
        set_wb(1, 6'd12);
        step();
        idle(); step();
        chk("bypass_iv", 32'(iss_valid), 1);
        chk("bypass_rob", 32'(iss_rob), 12);
        step();
        chk_log("bypass", '{12});

        // backpressure
        idle(); iss_ready = 1'b0; log_q.delete();
        set_port(0, 6'd1, 6'd1, 6'd20, 1'b1, 1'b1, 5'd20);
        set_port(1, 6'd1, 6'd1, 6'd21, 1'b1, 1'b1, 5'd21);
        step();
        idle(); step();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bp_hold_iv", 32'(iss_valid), 1);
            chk("bp_hold_rob", 32'(iss_rob), 20);
            chk("bp_hold_free", 32'(free_cnt), 7);
        end
        iss_ready = 1'b1;
        step();
        chk("bp_next_rob", 32'(iss_rob), 21);
        step();
        chk("bp_drain_iv", 32'(iss_valid), 0);
        chk_log("bp", '{20, 21});

        // flush mid-operation with concurrent dispatch
        idle(); iss_ready = 1'b0;
        set_port(0, 6'd1, 6'd1, 6'd1, 1'b1, 1'b1, 5'd1);
        set_port(1, 6'd1, 6'd1, 6'd2, 1'b1, 1'b1, 5'd2);
        set_port(2, 6'd1, 6'd1, 6'd3, 1'b1, 1'b1, 5'd3);
        step();
        idle();
        set_port(0, 6'd40, 6'd41, 6'd4, 1'b0, 1'b0, 5'd4);
        set_port(1, 6'd40, 6'd41, 6'd5, 1'b0, 1'b0, 5'd5);
        set_port(2, 6'd40, 6'd41, 6'd6, 1'b0, 1'b0, 5'd6);
        step();
        chk("pre_flush_iv", 32'(iss_valid), 1);
        chk("pre_flush_free", 32'(free_cnt), 3);
        idle(); flush = 1'b1;
        set_port(0, 6'd1, 6'd1, 6'd7, 1'b1, 1'b1, 5'd7);
        step();
        chk("flush_iv", 32'(iss_valid), 0);
        chk("flush_free", 32'(free_cnt), 8);
        idle(); iss_ready = 1'b1;
        step();
        chk("post_flush_iv", 32'(iss_valid), 0);

        // asynchronous reset mid-cycle
        idle(); iss_ready = 1'b0;
        set_port(0, 6'd2, 6'd3, 6'd4, 1'b1, 1'b1, 5'd25);
        step();
        idle(); step();
        chk("pre_rst_iv", 32'(iss_valid), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_iv", 32'(iss_valid), 0);
        chk("arst_free", 32'(free_cnt), 8);
        chk("arst_rob", 32'(iss_rob), 0);
        chk("arst_stall", 32'(disp_stall), 0);
        #3 rst = 1'b1;
        model_reset();
        iss_ready = 1'b1;
        @(posedge clk);
        #1;

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            idle();
            for (int p = 0; p < DISP_N; p++)
                if ($urandom_range(0, 99) < 45)
                    set_port(p, PREG_W'($urandom_range(0, 15)), PREG_W'($urandom_range(0, 15)),
                             PREG_W'($urandom_range(0, 63)), $urandom_range(0, 99) < 30,
                             $urandom_range(0, 99) < 30, ROB_W'($urandom_range(0, 31)));
            for (int j = 0; j < WB_N; j++)
                if ($urandom_range(0, 99) < 50) set_wb(j, PREG_W'($urandom_range(0, 15)));
            iss_ready = $urandom_range(0, 99) < 70;
            flush     = $urandom_range(0, 199) == 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
